// File: rtl/btn_pkg.sv
// Shared definitions for the button repeat encoder: event-kind encoding,
// button index constants and default timing parameters.
package btn_pkg;

  // Event kind as presented on evt_kind_o
  typedef enum logic [1:0] {
    KIND_PRESS  = 2'd0,
    KIND_REPEAT = 2'd1,
    KIND_LONG   = 2'd2
  } evt_kind_e;

  // Physical button order on btn_i / btns_posedge
  localparam int BTN_CENTER = 0;
  localparam int BTN_TOP    = 1;
  localparam int BTN_RIGHT  = 2;
  localparam int BTN_BOTTOM = 3;
  localparam int BTN_LEFT   = 4;

  // Default configuration
  localparam int DEF_NUM_BTNS  = 5;
  localparam int DEF_DELAY_CYC = 25_000_000;
  localparam int DEF_RATE_CYC  = 5_000_000;
  localparam int DEF_LONG_CYC  = 100_000_000;

  // Largest of three values, used to size the hold counters
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_repeat_fsm.sv
// One button channel: IDLE/HOLD/RPT state machine, saturating hold counters
// and a single-entry pending event register drained by the top-level arbiter.
// Optional feature macro: BTN_LONG_PRESS_EN adds the one-shot LONG event.
module btn_repeat_fsm
  import btn_pkg::*;
#(
  parameter int DELAY_CYC = DEF_DELAY_CYC,
  parameter int RATE_CYC  = DEF_RATE_CYC,
  parameter int LONG_CYC  = DEF_LONG_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       btn_posedge,
  input  logic       drain,
  output logic       pend_valid,
  output logic [1:0] pend_kind,
  output logic       drop
);

  localparam int CW = $clog2(max3(DELAY_CYC, RATE_CYC, LONG_CYC)) + 1;
  localparam logic [CW-1:0] DELAY_C = CW'(DELAY_CYC);
  localparam logic [CW-1:0] RATE_C  = CW'(RATE_CYC);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_RPT = 2'd2} state_e;

  state_e          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            gen_valid_s;
  logic [1:0]      gen_kind_s;
  logic            evt_valid_s;
  logic [1:0]      evt_kind_s;
  logic            pend_valid_r;
  logic [1:0]      pend_kind_r;

  // Counters stop at all-ones instead of wrapping
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + ONE_C;
  endfunction

  // State and delay/rate counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next state, counter update and PRESS/REPEAT generation; cnt equals cycles since press or last REPEAT
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    gen_valid_s = 1'b0;
    gen_kind_s  = KIND_PRESS;
    case (state_r)
      ST_IDLE: begin
        if (btn_posedge) begin
          state_s     = ST_HOLD;
          cnt_s       = ONE_C;
          gen_valid_s = 1'b1;
          gen_kind_s  = KIND_PRESS;
        end else begin
          cnt_s = '0;
        end
      end
      ST_HOLD: begin
        if (!btn) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else if (cnt_r == DELAY_C) begin
          state_s     = ST_RPT;
          cnt_s       = ONE_C;
          gen_valid_s = 1'b1;
          gen_kind_s  = KIND_REPEAT;
        end else begin
          cnt_s = sat_inc(cnt_r);
        end
      end
      ST_RPT: begin
        if (!btn) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else if (cnt_r == RATE_C) begin
          cnt_s       = ONE_C;
          gen_valid_s = 1'b1;
          gen_kind_s  = KIND_REPEAT;
        end else begin
          cnt_s = sat_inc(cnt_r);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

`ifdef BTN_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_C = CW'(LONG_CYC);
  logic [CW-1:0] hold_r, hold_s;
  logic          long_hit_s;

  // Total hold length since press, independent of the repeat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= '0;
    end else begin
      hold_r <= hold_s;
    end
  end

  // Hold counter update and one-shot LONG detection (saturation keeps it single)
  always_comb begin
    hold_s     = hold_r;
    long_hit_s = 1'b0;
    if (state_r == ST_IDLE) begin
      hold_s = btn_posedge ? ONE_C : '0;
    end else if (!btn) begin
      hold_s = '0;
    end else begin
      hold_s     = sat_inc(hold_r);
      long_hit_s = (hold_r == LONG_C);
    end
  end

  // LONG replaces a coincident REPEAT rather than competing for the pending slot
  always_comb begin
    evt_valid_s = gen_valid_s | long_hit_s;
    if (long_hit_s) begin
      evt_kind_s = KIND_LONG;
    end else begin
      evt_kind_s = gen_kind_s;
    end
  end
`else
  // Without the long-press feature only PRESS/REPEAT reach the pending slot
  always_comb begin
    evt_valid_s = gen_valid_s;
    evt_kind_s  = gen_kind_s;
  end
`endif

  // Single-entry pending slot; a draining slot may be refilled in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_r <= 1'b0;
      pend_kind_r  <= 2'd0;
    end else if (evt_valid_s && (!pend_valid_r || drain)) begin
      pend_valid_r <= 1'b1;
      pend_kind_r  <= evt_kind_s;
    end else if (drain) begin
      pend_valid_r <= 1'b0;
    end else begin
      pend_valid_r <= pend_valid_r;
    end
  end

  assign pend_valid = pend_valid_r;
  assign pend_kind  = pend_kind_r;
  assign drop       = evt_valid_s && pend_valid_r && !drain;

endmodule

// File: rtl/btn_repeat_encoder.sv
// Multi-button press/repeat event encoder: per-button channels feed a
// fixed-priority (lowest index first) arbiter and a valid/ready output register.
// Optional feature macro: BTN_LONG_PRESS_EN enables the LONG event kind.
module btn_repeat_encoder
  import btn_pkg::*;
#(
  parameter int NUM_BTNS  = DEF_NUM_BTNS,
  parameter int DELAY_CYC = DEF_DELAY_CYC,
  parameter int RATE_CYC  = DEF_RATE_CYC,
  parameter int LONG_CYC  = DEF_LONG_CYC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_i,
  input  logic [NUM_BTNS-1:0] btns_posedge,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [2:0]          evt_btn_o,
  output logic [1:0]          evt_kind_o,
  output logic                overrun_o
);

  logic [NUM_BTNS-1:0] pend_valid_s;
  logic [1:0]          pend_kind_s [NUM_BTNS];
  logic [NUM_BTNS-1:0] grant_s;
  logic [NUM_BTNS-1:0] drop_s;
  logic                load_s;
  logic                any_s;
  logic [2:0]          sel_btn_s;
  logic [1:0]          sel_kind_s;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_repeat_fsm #(
      .DELAY_CYC (DELAY_CYC),
      .RATE_CYC  (RATE_CYC),
      .LONG_CYC  (LONG_CYC)
    ) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn         (btn_i[g]),
      .btn_posedge (btns_posedge[g]),
      .drain       (grant_s[g]),
      .pend_valid  (pend_valid_s[g]),
      .pend_kind   (pend_kind_s[g]),
      .drop        (drop_s[g])
    );
  end

  assign load_s = !evt_valid_o || evt_ready_i;

  // Pick the lowest-index pending event and grant it when the output register loads
  always_comb begin
    any_s      = 1'b0;
    sel_btn_s  = 3'd0;
    sel_kind_s = 2'd0;
    grant_s    = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (pend_valid_s[i] && !any_s) begin
        any_s      = 1'b1;
        sel_btn_s  = 3'(i);
        sel_kind_s = pend_kind_s[i];
        grant_s[i] = load_s;
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  // Output register: refills whenever empty or being consumed, so ready=1 gives one event per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_o <= 1'b0;
      evt_btn_o   <= 3'd0;
      evt_kind_o  <= 2'd0;
    end else if (load_s && any_s) begin
      evt_valid_o <= 1'b1;
      evt_btn_o   <= sel_btn_s;
      evt_kind_o  <= sel_kind_s;
    end else if (load_s) begin
      evt_valid_o <= 1'b0;
    end else begin
      evt_valid_o <= evt_valid_o;
    end
  end

  // Sticky lost-event flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= overrun_o | (|drop_s);
    end
  end

endmodule

// File: tb/tb_btn_repeat_encoder.sv
// Directed bench for btn_repeat_encoder with DELAY=8, RATE=4, LONG=20.
// Cycle c of a scenario is the interval following the c-th rising edge;
// inputs change and outputs are sampled 1 ns after that edge.
module tb_btn_repeat_encoder;
  import btn_pkg::*;

  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_i = '0;
  logic [NB-1:0] btns_posedge = '0;
  logic          evt_ready_i = 1'b1;
  logic          evt_valid_o;
  logic [2:0]    evt_btn_o;
  logic [1:0]    evt_kind_o;
  logic          overrun_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  btn_repeat_encoder #(
    .NUM_BTNS  (NB),
    .DELAY_CYC (8),
    .RATE_CYC  (4),
    .LONG_CYC  (20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_i        (btn_i),
    .btns_posedge (btns_posedge),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (evt_ready_i),
    .evt_btn_o    (evt_btn_o),
    .evt_kind_o   (evt_kind_o),
    .overrun_o    (overrun_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic v, input logic [2:0] b, input logic [1:0] k);
    chk({tag, "/valid"}, {3'd0, evt_valid_o}, {3'd0, v});
    if (v) begin
      chk({tag, "/btn"}, {1'b0, evt_btn_o}, {1'b0, b});
      chk({tag, "/kind"}, {2'd0, evt_kind_o}, {2'd0, k});
    end
  endtask

  initial begin
    int g;
    logic ev;
    logic [1:0] k;

    // Reset state
    tick(); tick(); tick();
    chk("rst/valid", {3'd0, evt_valid_o}, 4'd0);
    chk("rst/btn", {1'b0, evt_btn_o}, 4'd0);
    chk("rst/kind", {2'd0, evt_kind_o}, 4'd0);
    chk("rst/ovr", {3'd0, overrun_o}, 4'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Short press on btn 2: high cycles 0..2, single PRESS visible at cycle 2
    for (int c = 0; c < 8; c++) begin
      btn_i        = (c < 3) ? 5'b00100 : 5'b00000;
      btns_posedge = (c == 0) ? 5'b00100 : 5'b00000;
      chk_evt($sformatf("short c%0d", c), (c == 2), 3'd2, 2'd0);
      tick();
    end

    // Long hold on btn 0: cycles 0..29; REPEAT at 8,12,..,28 (LONG at 20 with the macro)
    for (int c = 0; c < 40; c++) begin
      btn_i        = (c < 30) ? 5'b00001 : 5'b00000;
      btns_posedge = (c == 0) ? 5'b00001 : 5'b00000;
      g  = c - 2;
      ev = (g == 0) || (g >= 8 && g <= 28 && ((g - 8) % 4 == 0));
      k  = (g == 0) ? 2'd0 : 2'd1;
`ifdef BTN_LONG_PRESS_EN
      if (g == 20) k = 2'd2;
`endif
      chk_evt($sformatf("hold c%0d", c), ev, 3'd0, k);
      tick();
    end
    chk("hold/ovr", {3'd0, overrun_o}, 4'd0);

    // Simultaneous press of btn 4 and btn 1: btn 1 first, btn 4 next cycle
    btn_i = 5'b10010; btns_posedge = 5'b10010;
    tick();
    btns_posedge = 5'b00000;
    chk_evt("simul c1", 1'b0, 3'd0, 2'd0);
    tick();
    chk_evt("simul c2", 1'b1, 3'd1, 2'd0);
    btn_i = 5'b00000;
    tick();
    chk_evt("simul c3", 1'b1, 3'd4, 2'd0);
    tick();
    chk_evt("simul c4", 1'b0, 3'd0, 2'd0);
    tick(); tick();

    // Backpressure on btn 3: held cycles 0..12 with ready low, REPEATs at 8 and 12
    evt_ready_i = 1'b0;
    for (int c = 0; c < 14; c++) begin
      btn_i        = (c < 13) ? 5'b01000 : 5'b00000;
      btns_posedge = (c == 0) ? 5'b01000 : 5'b00000;
      if (c >= 2) chk_evt($sformatf("bp c%0d", c), 1'b1, 3'd3, 2'd0);
      chk($sformatf("bp ovr c%0d", c), {3'd0, overrun_o}, {3'd0, (c >= 13)});
      tick();
    end
    evt_ready_i = 1'b1;
    chk_evt("bp c14", 1'b1, 3'd3, 2'd0);
    tick();
    chk_evt("bp c15", 1'b1, 3'd3, 2'd1);
    tick();
    chk_evt("bp c16", 1'b0, 3'd0, 2'd0);
    chk("bp ovr c16", {3'd0, overrun_o}, 4'd1);
    tick();

    // Reset mid-hold on btn 0 with the PRESS parked on the output
    evt_ready_i = 1'b0;
    btn_i = 5'b00001; btns_posedge = 5'b00001;
    tick();
    btns_posedge = 5'b00000;
    tick(); tick(); tick();
    chk_evt("rmh c4", 1'b1, 3'd0, 2'd0);
    chk("rmh ovr c4", {3'd0, overrun_o}, 4'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rmh/valid", {3'd0, evt_valid_o}, 4'd0);
    chk("rmh/ovr", {3'd0, overrun_o}, 4'd0);
    chk("rmh/btn", {1'b0, evt_btn_o}, 4'd0);
    chk("rmh/kind", {2'd0, evt_kind_o}, 4'd0);
    tick(); tick();
    rst_n = 1'b1;
    evt_ready_i = 1'b1;
    for (int c = 7; c < 35; c++) begin
      btn_i = (c < 30) ? 5'b00001 : 5'b00000;
      chk_evt($sformatf("rmh quiet c%0d", c), 1'b0, 3'd0, 2'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
